// File: rtl/tl_ul_data_upsizer.sv
// TL-UL A/D data-width upsizer: packs narrow host Put bursts into wide device beats and splits
// wide responses into host beats. Define TL_UL_UPSIZER_REGSLICE_EN for registered device-side slices.
`ifdef TL_UL_UPSIZER_REGSLICE_EN
module tl_ul_upsizer_slice #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);
  logic [Width-1:0] mem [2];
  logic             wr_ptr, rd_ptr, push, pop;
  logic [1:0]       cnt;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule
`endif

module tl_ul_data_upsizer #(
  parameter int HostDataWidth   = 32,
  parameter int DeviceDataWidth = 64,
  parameter int AddrWidth       = 56,
  parameter int SourceWidth     = 2,
  parameter int MaxSize         = 6,
  localparam int SizeWidth      = $clog2(MaxSize + 1),
  localparam int HostBytes      = HostDataWidth / 8,
  localparam int DevBytes       = DeviceDataWidth / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       host_a_valid,
  output logic                       host_a_ready,
  input  logic [2:0]                 host_a_opcode,
  input  logic [2:0]                 host_a_param,
  input  logic [SizeWidth-1:0]       host_a_size,
  input  logic [SourceWidth-1:0]     host_a_source,
  input  logic [AddrWidth-1:0]       host_a_address,
  input  logic [HostBytes-1:0]       host_a_mask,
  input  logic [HostDataWidth-1:0]   host_a_data,
  input  logic                       host_a_corrupt,
  output logic                       host_d_valid,
  input  logic                       host_d_ready,
  output logic [2:0]                 host_d_opcode,
  output logic [2:0]                 host_d_param,
  output logic [SizeWidth-1:0]       host_d_size,
  output logic [SourceWidth-1:0]     host_d_source,
  output logic                       host_d_sink,
  output logic                       host_d_denied,
  output logic [HostDataWidth-1:0]   host_d_data,
  output logic                       host_d_corrupt,
  output logic                       device_a_valid,
  input  logic                       device_a_ready,
  output logic [2:0]                 device_a_opcode,
  output logic [2:0]                 device_a_param,
  output logic [SizeWidth-1:0]       device_a_size,
  output logic [SourceWidth-1:0]     device_a_source,
  output logic [AddrWidth-1:0]       device_a_address,
  output logic [DevBytes-1:0]        device_a_mask,
  output logic [DeviceDataWidth-1:0] device_a_data,
  output logic                       device_a_corrupt,
  input  logic                       device_d_valid,
  output logic                       device_d_ready,
  input  logic [2:0]                 device_d_opcode,
  input  logic [2:0]                 device_d_param,
  input  logic [SizeWidth-1:0]       device_d_size,
  input  logic [SourceWidth-1:0]     device_d_source,
  input  logic                       device_d_sink,
  input  logic                       device_d_denied,
  input  logic [DeviceDataWidth-1:0] device_d_data,
  input  logic                       device_d_corrupt
);
  localparam int Ratio  = DeviceDataWidth / HostDataWidth;
  localparam int OffW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int LogDB  = $clog2(DevBytes);
  localparam int BeatW  = MaxSize - LogDB + 1;
  localparam int NumSrc = 2 ** SourceWidth;
  localparam logic [2:0] OpPutFull = 3'd0, OpPutPartial = 3'd1, OpAckData = 3'd1;

  if (DeviceDataWidth <= HostDataWidth) begin : g_width_check
    $fatal(1, "DeviceDataWidth must exceed HostDataWidth");
  end

  logic                 tbl_valid [NumSrc];
  logic [OffW-1:0]      tbl_off   [NumSrc];
  logic [SizeWidth-1:0] tbl_size  [NumSrc];

  // A channel: device-side view (before the optional slice)
  logic                       da_valid, da_ready, da_corrupt, da_hs;
  logic [DevBytes-1:0]        da_mask, pack_mask;
  logic [DeviceDataWidth-1:0] da_data, pack_data;
  logic [HostDataWidth-1:0]   lane_data [Ratio];
  logic [HostBytes-1:0]       lane_mask [Ratio];
  logic [OffW-1:0]            a_sub, a_off;
  logic [BeatW-1:0]           a_beat, a_last_beat;
  logic                       a_valid, a_ready, a_first, a_pack, a_lock, a_sub_last, a_hs, corrupt_acc;

  assign a_valid     = rst_ni && host_a_valid;
  assign a_off       = host_a_address[LogDB-1 -: OffW];
  assign a_first     = (a_sub == '0) && (a_beat == '0);
  assign a_pack      = ((host_a_opcode == OpPutFull) || (host_a_opcode == OpPutPartial)) &&
                       (host_a_size >= SizeWidth'(LogDB));
  assign a_lock      = a_first && tbl_valid[host_a_source];
  assign a_sub_last  = (a_sub == OffW'(Ratio - 1));
  assign a_last_beat = BeatW'((1 << (host_a_size - SizeWidth'(LogDB))) - 1);

  always_comb begin
    pack_data = '0;
    pack_mask = '0;
    for (int i = 0; i < Ratio - 1; i++) begin
      pack_data[i*HostDataWidth +: HostDataWidth] = lane_data[i];
      pack_mask[i*HostBytes +: HostBytes]         = lane_mask[i];
    end
    pack_data[(Ratio-1)*HostDataWidth +: HostDataWidth] = host_a_data;
    pack_mask[(Ratio-1)*HostBytes +: HostBytes]         = host_a_mask;
  end

  always_comb begin
    da_valid = 1'b0;
    a_ready  = 1'b0;
    if (a_lock) begin
      a_ready = 1'b0;
    end else if (a_pack && !a_sub_last) begin
      a_ready = 1'b1;
    end else begin
      da_valid = a_valid;
      a_ready  = da_ready;
    end
  end

  assign host_a_ready = rst_ni && a_ready;
  assign da_data      = a_pack ? pack_data : {Ratio{host_a_data}};
  assign da_mask      = a_pack ? pack_mask : (DevBytes'(host_a_mask) << (HostBytes * a_off));
  assign da_corrupt   = a_pack ? (corrupt_acc | host_a_corrupt) : host_a_corrupt;
  assign a_hs         = a_valid && host_a_ready;
  assign da_hs        = da_valid && da_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_sub       <= '0;
      a_beat      <= '0;
      corrupt_acc <= 1'b0;
      for (int i = 0; i < Ratio; i++) begin
        lane_data[i] <= '0;
        lane_mask[i] <= '0;
      end
    end else if (a_hs && a_pack) begin
      if (!a_sub_last) begin
        lane_data[a_sub] <= host_a_data;
        lane_mask[a_sub] <= host_a_mask;
        corrupt_acc      <= corrupt_acc | host_a_corrupt;
        a_sub            <= a_sub + 1'b1;
      end else begin
        a_sub       <= '0;
        corrupt_acc <= 1'b0;
        a_beat      <= (a_beat == a_last_beat) ? '0 : a_beat + 1'b1;
      end
    end
  end

  // D channel: core-side view (after the optional slice)
  logic                       dd_valid, dd_ready, dd_sink, dd_denied, dd_corrupt;
  logic [2:0]                 dd_opcode, dd_param;
  logic [SizeWidth-1:0]       dd_size;
  logic [SourceWidth-1:0]     dd_source;
  logic [DeviceDataWidth-1:0] dd_data;
  logic [OffW-1:0]            d_sub, d_lane;
  logic [BeatW-1:0]           d_beat, d_last_beat;
  logic                       d_wide, d_sub_last, d_hs, d_msg_last;

  assign d_wide      = (dd_opcode == OpAckData) && (dd_size >= SizeWidth'(LogDB));
  assign d_sub_last  = (d_sub == OffW'(Ratio - 1));
  assign d_last_beat = BeatW'((1 << (dd_size - SizeWidth'(LogDB))) - 1);
  // Lane offset only means something for sub-device-width requests.
  assign d_lane      = d_wide ? d_sub :
                       ((tbl_size[dd_source] < SizeWidth'(LogDB)) ? tbl_off[dd_source] : '0);
  assign d_msg_last  = !d_wide || (d_sub_last && (d_beat == d_last_beat));

  assign host_d_valid   = rst_ni && dd_valid;
  assign dd_ready       = rst_ni && host_d_ready && (!d_wide || d_sub_last);
  assign host_d_opcode  = dd_opcode;
  assign host_d_param   = dd_param;
  assign host_d_size    = dd_size;
  assign host_d_source  = dd_source;
  assign host_d_sink    = dd_sink;
  assign host_d_denied  = dd_denied;
  assign host_d_corrupt = dd_corrupt;
  assign host_d_data    = dd_data[d_lane*HostDataWidth +: HostDataWidth];
  assign d_hs           = host_d_valid && host_d_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_sub  <= '0;
      d_beat <= '0;
    end else if (d_hs && d_wide) begin
      d_sub <= d_sub_last ? '0 : d_sub + 1'b1;
      if (d_sub_last) d_beat <= (d_beat == d_last_beat) ? '0 : d_beat + 1'b1;
    end
  end

  // Set is written after clear so a same-cycle set of the same entry wins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSrc; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_off[i]   <= '0;
        tbl_size[i]  <= '0;
      end
    end else begin
      if (d_hs && d_msg_last) tbl_valid[dd_source] <= 1'b0;
      if (da_hs && (a_beat == '0)) begin
        tbl_valid[host_a_source] <= 1'b1;
        tbl_off[host_a_source]   <= a_off;
        tbl_size[host_a_source]  <= host_a_size;
      end
    end
  end

`ifdef TL_UL_UPSIZER_REGSLICE_EN
  localparam int APktW = 6 + SizeWidth + SourceWidth + AddrWidth + DevBytes + DeviceDataWidth + 1;
  localparam int DPktW = 6 + SizeWidth + SourceWidth + 2 + DeviceDataWidth + 1;
  logic a_out_valid, d_in_ready;

  tl_ul_upsizer_slice #(.Width(APktW)) u_a_slice (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (da_valid),
    .in_ready  (da_ready),
    .in_data   ({host_a_opcode, host_a_param, host_a_size, host_a_source, host_a_address,
                 da_mask, da_data, da_corrupt}),
    .out_valid (a_out_valid),
    .out_ready (device_a_ready),
    .out_data  ({device_a_opcode, device_a_param, device_a_size, device_a_source, device_a_address,
                 device_a_mask, device_a_data, device_a_corrupt})
  );
  assign device_a_valid = rst_ni && a_out_valid;

  tl_ul_upsizer_slice #(.Width(DPktW)) u_d_slice (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (device_d_valid),
    .in_ready  (d_in_ready),
    .in_data   ({device_d_opcode, device_d_param, device_d_size, device_d_source, device_d_sink,
                 device_d_denied, device_d_data, device_d_corrupt}),
    .out_valid (dd_valid),
    .out_ready (dd_ready),
    .out_data  ({dd_opcode, dd_param, dd_size, dd_source, dd_sink, dd_denied, dd_data, dd_corrupt})
  );
  assign device_d_ready = rst_ni && d_in_ready;
`else
  assign device_a_valid   = da_valid;
  assign da_ready         = device_a_ready;
  assign device_a_opcode  = host_a_opcode;
  assign device_a_param   = host_a_param;
  assign device_a_size    = host_a_size;
  assign device_a_source  = host_a_source;
  assign device_a_address = host_a_address;
  assign device_a_mask    = da_mask;
  assign device_a_data    = da_data;
  assign device_a_corrupt = da_corrupt;

  assign dd_valid       = device_d_valid;
  assign device_d_ready = dd_ready;
  assign dd_opcode      = device_d_opcode;
  assign dd_param       = device_d_param;
  assign dd_size        = device_d_size;
  assign dd_source      = device_d_source;
  assign dd_sink        = device_d_sink;
  assign dd_denied      = device_d_denied;
  assign dd_data        = device_d_data;
  assign dd_corrupt     = device_d_corrupt;
`endif
endmodule

// File: tb/tb_tl_ul_data_upsizer.sv
// Directed bench for tl_ul_data_upsizer in its 32->64 bit configuration.
module tb_tl_ul_data_upsizer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_a_valid, host_a_ready, host_a_corrupt;
  logic [2:0]  host_a_opcode, host_a_param, host_a_size;
  logic [1:0]  host_a_source;
  logic [55:0] host_a_address;
  logic [3:0]  host_a_mask;
  logic [31:0] host_a_data;
  logic        host_d_valid, host_d_ready, host_d_sink, host_d_denied, host_d_corrupt;
  logic [2:0]  host_d_opcode, host_d_param, host_d_size;
  logic [1:0]  host_d_source;
  logic [31:0] host_d_data;
  logic        device_a_valid, device_a_ready, device_a_corrupt;
  logic [2:0]  device_a_opcode, device_a_param, device_a_size;
  logic [1:0]  device_a_source;
  logic [55:0] device_a_address;
  logic [7:0]  device_a_mask;
  logic [63:0] device_a_data;
  logic        device_d_valid, device_d_ready, device_d_sink, device_d_denied, device_d_corrupt;
  logic [2:0]  device_d_opcode, device_d_param, device_d_size;
  logic [1:0]  device_d_source;
  logic [63:0] device_d_data;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tl_ul_data_upsizer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_opcode(host_a_opcode),
    .host_a_param(host_a_param), .host_a_size(host_a_size), .host_a_source(host_a_source),
    .host_a_address(host_a_address), .host_a_mask(host_a_mask), .host_a_data(host_a_data),
    .host_a_corrupt(host_a_corrupt),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_opcode(host_d_opcode),
    .host_d_param(host_d_param), .host_d_size(host_d_size), .host_d_source(host_d_source),
    .host_d_sink(host_d_sink), .host_d_denied(host_d_denied), .host_d_data(host_d_data),
    .host_d_corrupt(host_d_corrupt),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a_opcode(device_a_opcode),
    .device_a_param(device_a_param), .device_a_size(device_a_size), .device_a_source(device_a_source),
    .device_a_address(device_a_address), .device_a_mask(device_a_mask), .device_a_data(device_a_data),
    .device_a_corrupt(device_a_corrupt),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d_opcode(device_d_opcode),
    .device_d_param(device_d_param), .device_d_size(device_d_size), .device_d_source(device_d_source),
    .device_d_sink(device_d_sink), .device_d_denied(device_d_denied), .device_d_data(device_d_data),
    .device_d_corrupt(device_d_corrupt)
  );

  task automatic idle();
    host_a_valid = 1'b0; host_a_opcode = 3'd0; host_a_param = 3'd0; host_a_size = 3'd0;
    host_a_source = 2'd0; host_a_address = '0; host_a_mask = 4'h0; host_a_data = '0; host_a_corrupt = 1'b0;
    host_d_ready = 1'b1; device_a_ready = 1'b1;
    device_d_valid = 1'b0; device_d_opcode = 3'd0; device_d_param = 3'd0; device_d_size = 3'd0;
    device_d_source = 2'd0; device_d_sink = 1'b0; device_d_denied = 1'b0; device_d_data = '0;
    device_d_corrupt = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                         input logic [55:0] addr, input logic [3:0] msk, input logic [31:0] dat);
    host_a_valid = 1'b1; host_a_opcode = op; host_a_size = sz; host_a_source = src;
    host_a_address = addr; host_a_mask = msk; host_a_data = dat;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                         input logic [63:0] dat);
    device_d_valid = 1'b1; device_d_opcode = op; device_d_size = sz; device_d_source = src;
    device_d_data = dat;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    drive_a(3'd0, 3'd3, 2'd0, 56'h100, 4'hF, 32'h1);
    drive_d(3'd1, 3'd3, 2'd0, 64'h1);
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_a_ready: got %0h want 0", host_a_ready); end
    n_cmp++; if (device_a_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dev_a_valid: got %0h want 0", device_a_valid); end
    n_cmp++; if (host_d_valid !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid: got %0h want 0", host_d_valid); end
    n_cmp++; if (device_d_ready !== 1'b0) begin n_bad++; $display("FAIL rst_dev_d_ready: got %0h want 0", device_d_ready); end
    cyc(); cyc();
    idle();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_put_pack();
    drive_a(3'd0, 3'd3, 2'd0, 56'h100, 4'hF, 32'h11111111);
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b1) begin n_bad++; $display("FAIL pack_b0_ready: got %0h want 1", host_a_ready); end
    n_cmp++; if (device_a_valid !== 1'b0) begin n_bad++; $display("FAIL pack_b0_dev_valid: got %0h want 0", device_a_valid); end
    cyc();
    drive_a(3'd0, 3'd3, 2'd0, 56'h100, 4'hF, 32'h22222222);
    device_a_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b0) begin n_bad++; $display("FAIL pack_b1_stall_ready: got %0h want 0", host_a_ready); end
    n_cmp++; if (device_a_valid !== 1'b1) begin n_bad++; $display("FAIL pack_b1_dev_valid: got %0h want 1", device_a_valid); end
    device_a_ready = 1'b1;
    #1;
    n_cmp++; if (host_a_ready !== 1'b1) begin n_bad++; $display("FAIL pack_b1_ready: got %0h want 1", host_a_ready); end
    n_cmp++; if (device_a_data !== 64'h22222222_11111111) begin n_bad++; $display("FAIL pack_data: got %h want 2222222211111111", device_a_data); end
    n_cmp++; if (device_a_mask !== 8'hFF) begin n_bad++; $display("FAIL pack_mask: got %h want ff", device_a_mask); end
    n_cmp++; if (device_a_size !== 3'd3) begin n_bad++; $display("FAIL pack_size: got %0d want 3", device_a_size); end
    cyc();
    host_a_valid = 1'b0;
    drive_d(3'd0, 3'd3, 2'd0, 64'h0);
    @(negedge clk);
    n_cmp++; if (host_d_valid !== 1'b1) begin n_bad++; $display("FAIL ack_valid: got %0h want 1", host_d_valid); end
    n_cmp++; if (device_d_ready !== 1'b1) begin n_bad++; $display("FAIL ack_dev_ready: got %0h want 1", device_d_ready); end
    n_cmp++; if (host_d_opcode !== 3'd0) begin n_bad++; $display("FAIL ack_opcode: got %0d want 0", host_d_opcode); end
    cyc();
    device_d_valid = 1'b0;
  endtask

  task automatic test_put_narrow();
    drive_a(3'd0, 3'd2, 2'd0, 56'h104, 4'hF, 32'hAABBCCDD);
    @(negedge clk);
    n_cmp++; if (device_a_valid !== 1'b1) begin n_bad++; $display("FAIL narrow_dev_valid: got %0h want 1", device_a_valid); end
    n_cmp++; if (device_a_mask !== 8'hF0) begin n_bad++; $display("FAIL narrow_mask: got %h want f0", device_a_mask); end
    n_cmp++; if (device_a_data[63:32] !== 32'hAABBCCDD) begin n_bad++; $display("FAIL narrow_upper: got %h want aabbccdd", device_a_data[63:32]); end
    cyc();
    host_a_valid = 1'b0;
    drive_d(3'd0, 3'd2, 2'd0, 64'h0);
    cyc();
    device_d_valid = 1'b0;
  endtask

  task automatic test_get_narrow();
    drive_a(3'd4, 3'd2, 2'd1, 56'h104, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (device_a_valid !== 1'b1) begin n_bad++; $display("FAIL get_dev_valid: got %0h want 1", device_a_valid); end
    n_cmp++; if (device_a_mask !== 8'hF0) begin n_bad++; $display("FAIL get_mask: got %h want f0", device_a_mask); end
    cyc();
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b0) begin n_bad++; $display("FAIL get_lock_ready: got %0h want 0", host_a_ready); end
    n_cmp++; if (device_a_valid !== 1'b0) begin n_bad++; $display("FAIL get_lock_dev_valid: got %0h want 0", device_a_valid); end
    host_a_valid = 1'b0;
    drive_d(3'd1, 3'd2, 2'd1, 64'h55667788_11223344);
    #1;
    n_cmp++; if (host_d_data !== 32'h55667788) begin n_bad++; $display("FAIL get_rsp_data: got %h want 55667788", host_d_data); end
    n_cmp++; if (device_d_ready !== 1'b1) begin n_bad++; $display("FAIL get_rsp_ready: got %0h want 1", device_d_ready); end
    cyc();
    device_d_valid = 1'b0;
    drive_a(3'd4, 3'd2, 2'd1, 56'h104, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b1) begin n_bad++; $display("FAIL get_freed_ready: got %0h want 1", host_a_ready); end
    host_a_valid = 1'b0;
    cyc();
  endtask

  task automatic test_get_burst();
    logic [31:0] lo, hi;
    drive_a(3'd4, 3'd6, 2'd0, 56'h0, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (device_a_mask !== 8'h0F) begin n_bad++; $display("FAIL burst_mask: got %h want 0f", device_a_mask); end
    cyc();
    host_a_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lo = 32'h10000000 + k;
      hi = 32'h20000000 + k;
      drive_d(3'd1, 3'd6, 2'd0, {hi, lo});
      host_d_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (host_d_data !== lo) begin n_bad++; $display("FAIL burst_lo%0d: got %h want %h", k, host_d_data, lo); end
      n_cmp++; if (device_d_ready !== 1'b0) begin n_bad++; $display("FAIL burst_lo_ready%0d: got %0h want 0", k, device_d_ready); end
      cyc();
      host_d_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (host_d_data !== hi) begin n_bad++; $display("FAIL burst_hold%0d: got %h want %h", k, host_d_data, hi); end
      n_cmp++; if (device_d_ready !== 1'b0) begin n_bad++; $display("FAIL burst_hold_ready%0d: got %0h want 0", k, device_d_ready); end
      cyc();
      host_d_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (host_d_data !== hi) begin n_bad++; $display("FAIL burst_hi%0d: got %h want %h", k, host_d_data, hi); end
      n_cmp++; if (device_d_ready !== 1'b1) begin n_bad++; $display("FAIL burst_hi_ready%0d: got %0h want 1", k, device_d_ready); end
      cyc();
    end
    device_d_valid = 1'b0;
    drive_a(3'd4, 3'd2, 2'd0, 56'h0, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b1) begin n_bad++; $display("FAIL burst_freed: got %0h want 1", host_a_ready); end
    host_a_valid = 1'b0;
    cyc();
  endtask

  task automatic test_out_of_order();
    drive_a(3'd4, 3'd2, 2'd0, 56'h0, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (device_a_mask !== 8'h0F) begin n_bad++; $display("FAIL ooo_src0_mask: got %h want 0f", device_a_mask); end
    cyc();
    drive_a(3'd4, 3'd2, 2'd1, 56'h4, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (device_a_mask !== 8'hF0) begin n_bad++; $display("FAIL ooo_src1_mask: got %h want f0", device_a_mask); end
    cyc();
    drive_a(3'd4, 3'd2, 2'd0, 56'h8, 4'hF, 32'h0);
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b0) begin n_bad++; $display("FAIL ooo_hold1: got %0h want 0", host_a_ready); end
    drive_d(3'd1, 3'd2, 2'd1, 64'hCAFEF00D_DEADBEEF);
    #1;
    n_cmp++; if (host_d_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL ooo_src1_data: got %h want cafef00d", host_d_data); end
    cyc();
    drive_d(3'd1, 3'd2, 2'd0, 64'h0BADC0DE_12345678);
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b0) begin n_bad++; $display("FAIL ooo_hold2: got %0h want 0", host_a_ready); end
    n_cmp++; if (host_d_data !== 32'h12345678) begin n_bad++; $display("FAIL ooo_src0_data: got %h want 12345678", host_d_data); end
    cyc();
    device_d_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (host_a_ready !== 1'b1) begin n_bad++; $display("FAIL ooo_release: got %0h want 1", host_a_ready); end
    n_cmp++; if (device_a_valid !== 1'b1) begin n_bad++; $display("FAIL ooo_release_valid: got %0h want 1", device_a_valid); end
    cyc();
    host_a_valid = 1'b0;
    drive_d(3'd1, 3'd2, 2'd0, 64'h99999999_77777777);
    @(negedge clk);
    n_cmp++; if (host_d_data !== 32'h77777777) begin n_bad++; $display("FAIL ooo_third_data: got %h want 77777777", host_d_data); end
    cyc();
    device_d_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_a(3'd0, 3'd3, 2'd3, 56'h200, 4'hF, 32'hDEADDEAD);
    cyc();
    drive_a(3'd0, 3'd3, 2'd3, 56'h200, 4'hF, 32'hBEEFBEEF);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (device_a_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_dev_valid: got %0h want 0", device_a_valid); end
    cyc();
    rst_n = 1'b1;
    drive_a(3'd0, 3'd3, 2'd3, 56'h200, 4'hF, 32'h33333333);
    @(negedge clk);
    n_cmp++; if (device_a_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_b0_valid: got %0h want 0", device_a_valid); end
    n_cmp++; if (host_a_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_b0_ready: got %0h want 1", host_a_ready); end
    cyc();
    drive_a(3'd0, 3'd3, 2'd3, 56'h200, 4'hF, 32'h44444444);
    @(negedge clk);
    n_cmp++; if (device_a_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_b1_valid: got %0h want 1", device_a_valid); end
    n_cmp++; if (device_a_data !== 64'h44444444_33333333) begin n_bad++; $display("FAIL rstmid_data: got %h want 4444444433333333", device_a_data); end
    cyc();
    host_a_valid = 1'b0;
    drive_d(3'd0, 3'd3, 2'd3, 64'h0);
    cyc();
    device_d_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_put_pack();
    test_put_narrow();
    test_get_narrow();
    test_get_burst();
    test_out_of_order();
    test_reset_mid();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
